// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage multiply/divide operand and result bundle
//
// Purpose: groups the signals exchanged between the EX stage and ex_muldiv.
// Ports (signals):
//   flush   EX flush; aborts any operation
//   start   EX holds a valid M-instruction
//   op      funct3 of the M-instruction
//   srcA    rs1 value after forwarding
//   srcB    rs2 value after forwarding
//   stall   combinational stall request to the hazard unit
//   busy    high while the unit is iterating
//   done    one-cycle result-valid pulse
//   result  final result, held until the next done
// Modports: master = pipeline side, slave = muldiv unit side.

interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output flush, start, op, srcA, srcB,
        input  stall, busy, done, result
    );

    modport slave (
        input  flush, start, op, srcA, srcB,
        output stall, busy, done, result
    );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
//
// Purpose: computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per
// cycle on operand magnitudes, fixing up the sign at the end. Holds the
// pipeline via stall until the result is ready.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   ex_muldiv_if.slave: flush/start/op/srcA/srcB in,
//         stall (comb), busy/done/result (registered) out

module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]    count;
    logic [2:0]       op_q;
    logic             neg_q;
    // Shared datapath. Multiply: {hi,lo} is the product shifting right with
    // the multiplier entering from lo. Divide: lo shifts the dividend out
    // and the quotient in, hi is the partial remainder.
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;

    // ---------------------------------------------------------------
    // Operand decode, only meaningful while IDLE
    // ---------------------------------------------------------------
    logic             op_div;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             res_neg;
    logic             b_zero;
    logic             div_ovf;
    logic             special;
    logic [WIDTH-1:0] special_val;
    logic             begin_op;

    always_comb begin
        op_div   = bus.op[2];
        // Divides: even funct3 is signed. Multiplies: MULHU is fully
        // unsigned, MULHSU has only srcA signed.
        a_signed = op_div ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
        b_signed = op_div ? ~bus.op[0] : ~bus.op[1];
        a_neg    = a_signed & bus.srcA[WIDTH-1];
        b_neg    = b_signed & bus.srcB[WIDTH-1];
        a_mag    = a_neg ? -bus.srcA : bus.srcA;
        b_mag    = b_neg ? -bus.srcB : bus.srcB;
        // Remainder takes the dividend's sign; everything else the xor.
        res_neg  = (op_div & bus.op[1]) ? a_neg : (a_neg ^ b_neg);

        b_zero   = (bus.srcB == '0);
        div_ovf  = op_div & ~bus.op[0]
                 & (bus.srcA == {1'b1, {(WIDTH-1){1'b0}}})
                 & (bus.srcB == '1);
        special  = op_div & (b_zero | div_ovf);

        if (b_zero) begin
            special_val = bus.op[1] ? bus.srcA : '1;
        end else begin
            special_val = bus.op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end

        begin_op = bus.start & ~bus.flush;
    end

    // ---------------------------------------------------------------
    // One iteration step and the final result it would produce
    // ---------------------------------------------------------------
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   hi_nx;
    logic [WIDTH-1:0]   lo_nx;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   div_val;
    logic [WIDTH-1:0]   final_val;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, mcand};

        if (op_q[2]) begin
            if (!diff[WIDTH]) begin
                hi_nx = diff[WIDTH-1:0];
                lo_nx = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = shifted[WIDTH-1:0];
                lo_nx = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], lo[WIDTH-1:1]};
        end

        // Negating the full product keeps both halves correct for MUL and MULH*.
        product  = {hi_nx, lo_nx};
        prod_fix = neg_q ? -product : product;
        div_val  = op_q[1] ? hi_nx : lo_nx;

        if (op_q[2]) begin
            final_val = neg_q ? -div_val : div_val;
        end else if (op_q[1:0] == 2'b00) begin
            final_val = prod_fix[WIDTH-1:0];
        end else begin
            final_val = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nx = state;
        if (bus.flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_nx = special ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (count == CW'(WIDTH - 1)) begin
                        state_nx = S_DONE;
                    end
                end
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM: combinational outputs
    // ---------------------------------------------------------------
    always_comb begin
        bus.stall = ((state == S_IDLE) & begin_op) | (state == S_CALC);
    end

    // ---------------------------------------------------------------
    // Datapath and registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            count      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            mcand      <= '0;
        end else begin
            bus.busy <= (state_nx == S_CALC);
            bus.done <= (state_nx == S_DONE);

            case (state)
                S_IDLE: begin
                    if (begin_op) begin
                        op_q  <= bus.op;
                        neg_q <= res_neg;
                        count <= '0;
                        hi    <= '0;
                        lo    <= op_div ? a_mag : b_mag;
                        mcand <= op_div ? b_mag : a_mag;
                        if (special) begin
                            bus.result <= special_val;
                        end
                    end
                end
                S_CALC: begin
                    if (!bus.flush) begin
                        hi    <= hi_nx;
                        lo    <= lo_nx;
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            bus.result <= final_val;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv

module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad = 0;
    int done_pulses = 0;
    logic [31:0] sb [$];
    logic [31:0] last_result;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb2, p;
        longint unsigned ua, ub, up;
        logic ovf;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sa * sb2; return p[31:0]; end
            3'd1: begin p = sa * sb2; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb2; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb2; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        return o[2] && ((b == 0) ||
               (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Called just after a rising edge; returns just after the edge closing the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit poke);
        int k;
        int stalls;
        int lat;
        bit busy_seen;
        bit got;
        logic [31:0] e;
        lat = is_special(o, a, b) ? 1 : 33;
        bus.op = o;
        bus.srcA = a;
        bus.srcB = b;
        bus.start = 1'b1;
        sb.push_back(exp);
        k = 0; stalls = 0; busy_seen = 0; got = 0;
        while (k < 80 && !got) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1;
            end else begin
                if (bus.stall === 1'b1) stalls++;
                if (bus.busy === 1'b1) busy_seen = 1;
                @(posedge clk);
                #1;
                k++;
                if (poke && k == 5) bus.srcA = ~a;
            end
        end
        e = sb.pop_front();
        check($sformatf("done_seen op%0d", o), 32'(got), 32'd1);
        check($sformatf("latency op%0d", o), 32'(k), 32'(lat));
        check($sformatf("stall_cycles op%0d", o), 32'(stalls), 32'(lat));
        check($sformatf("stall_in_done op%0d", o), 32'(bus.stall), 32'd0);
        check($sformatf("busy_seen op%0d", o), 32'(busy_seen), (lat == 1) ? 32'd0 : 32'd1);
        check($sformatf("result op%0d a=%h b=%h", o, a, b), bus.result, e);
        last_result = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int p0;
        logic [2:0] ro;
        logic [31:0] ra, rb;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.srcA = '0;
        bus.srcB = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset result", bus.result, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Multiplies
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        idle(1);
        run_op(3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        idle(1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        idle(1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
        idle(1);

        // Divides
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        idle(1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        idle(1);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 0);
        idle(1);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 0);
        idle(1);

        // Special cases
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        idle(1);
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 0);
        idle(1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        idle(1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        idle(1);

        // Back-to-back with start held; srcA changes mid-CALC on the second
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 0);
        run_op(3'd5, 32'd12, 32'd5, 32'd2, 1);
        idle(2);

        // Flush at CALC count=10
        p0 = done_pulses;
        bus.op = 3'd4; bus.srcA = 32'd1000; bus.srcB = 32'd3; bus.start = 1'b1;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush stall", 32'(bus.stall), 32'd0);
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush result", bus.result, last_result);
        idle(40);
        check("flush no done", 32'(done_pulses), 32'(p0));
        check("flush result held", bus.result, last_result);

        // Flush together with start in IDLE
        bus.op = 3'd5; bus.srcA = 32'd5; bus.srcB = 32'd0;
        bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        check("flush+start stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check("flush+start busy", 32'(bus.busy), 32'd0);
        check("flush+start done", 32'(bus.done), 32'd0);
        idle(2);

        // Reset at CALC count=10
        p0 = done_pulses;
        bus.op = 3'd4; bus.srcA = 32'd1000; bus.srcB = 32'd3; bus.start = 1'b1;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst result", bus.result, 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst stall", 32'(bus.stall), 32'd0);
        idle(40);
        check("rst no done", 32'(done_pulses), 32'(p0));

        // Random operations against the reference model
        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            run_op(ro, ra, rb, ref_model(ro, ra, rb), 0);
            idle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes forwarded EX operands and funct3, then computes the result over multiple cycles.
- Drives a stall request that freezes PC, IF/ID and ID/EX, so the M-instruction stays in EX until its result is ready.
- The result is muxed into the EX ALU-result path when `done` is high.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  EX flush (branch/jump redirect); aborts any operation
- start  input  1  EX holds a valid M-instruction (decoded muldiv & valid)
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srcA  input  WIDTH  rs1 value after forwarding
- srcB  input  WIDTH  rs2 value after forwarding
- stall  output  1  combinational stall request to hazard unit
- busy  output  1  registered; high while state is CALC
- done  output  1  registered one-cycle pulse; result valid
- result  output  WIDTH  registered final result; holds until next done

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, count=0, internal accumulators=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start=1 and flush=0, latch op, srcA and srcB.
  - Compute operand magnitudes: signed ops use |x|; for MULHSU only srcA is treated as signed.
  - Latch result sign:
    - MUL*: sign(A) xor sign(B), for the operands treated as signed.
    - DIV: sign(A) xor sign(B).
    - REM: sign(A).
  - Clear count. Go to CALC, or to DONE via the special-case path below.
- Special cases (decided in IDLE, skip CALC, go straight to DONE):
  - DIV/DIVU with srcB=0: quotient = all ones.
  - REM/REMU with srcB=0: remainder = srcA.
  - DIV with srcA=0x80000000 and srcB=0xFFFFFFFF: quotient = 0x80000000.
  - REM with the same overflow operands: remainder = 0.
- CALC, one iteration per cycle, count 0..WIDTH-1:
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - At count=WIDTH-1, go to DONE.
- DONE:
  - On entry, result is registered:
    - MUL: low word.
    - MULH/MULHSU/MULHU: high word.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Signed results are two's-complement negated when the latched sign is 1.
  - done=1 for exactly this cycle; start is ignored.
  - Next state is IDLE unconditionally.
- stall = (state==IDLE & start & !flush) | (state==CALC).
  - stall is 0 in DONE, so the pipeline advances on the DONE edge and the instruction leaves EX.
- Latency: start sampled at edge E0; normal done is high after edge E0+WIDTH+1 (33 cycles for WIDTH=32); special-case done is high after E0+1.
- flush: from any state, next state is IDLE, busy=0, done=0; result is not updated. flush together with start in IDLE means no operation starts.
- rst mid-operation: same as flush, and result is also cleared to 0.
- Operand inputs are ignored after the IDLE capture, so forwarding changes during a stall have no effect.
- Back-to-back M-instructions: the second one arrives in EX the cycle after DONE, sees state IDLE, and starts normally. There are no idle bubbles beyond the DONE cycle.

Test Plan:
- MUL 7 x -3 (srcA=7, srcB=0xFFFFFFFD) -> stall high 33 cycles, done pulse once, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU srcA=0xFFFFFFFF, srcB=2 -> result=0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with done at cycle 33.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF with done one cycle after start.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
  - In all four, busy is never asserted.
- Abort: start a DIV, assert flush at CALC count=10 -> next cycle state=IDLE, stall=0, no done pulse, result unchanged. Repeat with rst -> result=0.
- Back-to-back: MUL 3x4 then DIVU 12/5 with start held -> done pulses at cycles 33 and 67 with results 12 then 2. Change srcA mid-CALC -> result unaffected.
